bus_router: RTL and testbench
=============================

// Module: bus_router
// PURPOSE
//  Bus-cycle router downstream of the address decoder/MMU. Consumes the decoder's
//  chipselect and fault for the master's current cycle, and latches the select.
//  Drives one-hot strobes to up to 16 slaves and muxes the selected slave's read data
//  and ack back to the master. Converts decode faults and slave time-outs into err_o,
//  and records the first faulting address for the exception logic.
// PARAMETERS
//  NSLAVE   16   number of slave ports; select index 0 means "no slave"
//  DW       32   data width
//  TIMEOUT  255  cycles in ACTIVE without slave ack before bus error (1..2^CW-1)
//  CW       8    timeout counter width
// PORTS
//  clk_i          in   1         system clock
//  rst_n_i        in   1         asynchronous, active-low reset
//  cyc_i          in   1         master cycle valid
//  stb_i          in   1         master strobe
//  adr_i          in   32        master address; captured on fault
//  cs_i           in   4         chipselect from decoder, valid while cyc_i
//  fault_i        in   1         decode fault from decoder, valid while cyc_i
//  ack_o          out  1         one-cycle transfer-complete pulse to master
//  err_o          out  1         one-cycle bus-error pulse to master
//  dat_o          out  DW        registered read data, valid when ack_o=1
//  slv_stb_o      out  NSLAVE    one-hot strobe; bit k is asserted for cs=k, and bit 0 is never asserted
//  slv_ack_i      in   NSLAVE    slave acks
//  slv_dat_i      in   NSLAVE*DW flattened slave read data; slave k at [k*DW +: DW]
//  fault_valid_o  out  1         sticky: a fault has been captured
//  fault_cause_o  out  2         01 decode fault, 10 timeout
//  fault_adr_o    out  32        address of the captured fault
//  fault_ovr_o    out  1         sticky: another fault occurred while fault_valid_o=1
//  fault_clr_i    in   1         clears fault_valid_o and fault_ovr_o
// BEHAVIOUR
//  Reset:
//   - state=IDLE.
//   - All outputs are 0; dat_o=0; fault_adr_o=0; fault_cause_o=00.
//  IDLE, when cyc_i&stb_i:
//   - If fault_i=1 or cs_i=0: go to ERR and capture adr_i with cause 01.
//   - Otherwise: latch cs_q<=cs_i, load timer<=TIMEOUT, go to ACTIVE.
//  ACTIVE:
//   - slv_stb_o[cs_q]=1, driven combinationally from state and cs_q.
//   - If cyc_i=0: abort to IDLE. No ack and no err are issued.
//   - Else if slv_ack_i[cs_q]: dat_o<=slave data, go to RESP.
//   - Else if timer=1: capture the latched address with cause 10, go to ERR.
//   - Else: timer decrements.
//   - Ack and expiry in the same cycle: the ack wins.
//  RESP: ack_o=1 for one cycle, then IDLE.
//  ERR: err_o=1 for one cycle, then IDLE.
//  A new request is accepted in the cycle after RESP/ERR.
//  Latency:
//   - The request is sampled in IDLE at cycle N; slv_stb_o rises in N+1.
//   - The slave acks in cycle M>=N+1; ack_o is asserted in M+1.
//   - Minimum is 2 cycles from request to ack_o.
//  Slave inputs:
//   - Acks on slaves other than cs_q are ignored.
//   - slv_ack_i in IDLE is ignored.
//  Fault capture:
//   - A capture with fault_valid_o=0 loads adr/cause and sets valid.
//   - A capture with fault_valid_o=1 keeps the first record and sets fault_ovr_o.
//   - A capture in the same cycle as fault_clr_i: the new fault is loaded and ovr is cleared.
//  Address capture: adr_i is latched into adr_q when IDLE->ACTIVE; a timeout reports adr_q.
// STRUCTURE
//  bus_pkg: state enum {IDLE,ACTIVE,RESP,ERR}, cause codes CAUSE_DECODE=2'b01 and
//  CAUSE_TIMEOUT=2'b10, and the default TIMEOUT.
//  One sub-module, bus_timeout: a loadable down-counter with load/enable/expired.
//  Data mux, FSM and fault register are in this module.
// TESTING
//  1. Reset mid-ACTIVE: assert rst_n_i=0 with slv_stb_o[7]=1.
//     -> All outputs are 0 in the same cycle, state=IDLE.
//  2. Normal read: cs_i=7; slave 7 acks 3 cycles after its strobe with data 32'hDEADBEEF.
//     -> ack_o is one pulse, dat_o=32'hDEADBEEF, slv_stb_o=16'h0080 during ACTIVE.
//  3. Decode fault: adr_i=32'h10000000, fault_i=1.
//     -> err_o is pulsed 1 cycle later, fault_adr_o=32'h10000000, cause=01, no slave strobe.
//  4. Timeout: TIMEOUT=4, cs_i=3, slave never acks.
//     -> err_o is asserted 5 cycles after the request, cause=10.
//     -> A second fault before fault_clr_i sets fault_ovr_o and keeps the first address.
//  5. Edge cases:
//     -> An ack on the exact expiry cycle gives ack_o and no err_o.
//     -> cyc_i dropped in ACTIVE gives neither pulse and a return to IDLE.
//     -> An ack on a non-selected slave is ignored.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus router.
// State encoding, fault cause codes and default timeout.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP,
        ERR
    } state_e;

    localparam logic [1:0] CAUSE_DECODE  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam int         TIMEOUT_DEF   = 255;
    localparam int         CW_DEF        = 8;

endpackage

// File: rtl/bus_timeout.sv
// Loadable down-counter that flags expiry when it reaches one.
// Used to bound how long a slave may leave a cycle unacknowledged.
module bus_timeout #(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] val_i,
    output logic          expired_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CW'(1));

endmodule

// File: rtl/bus_router.sv
// Routes the master's bus cycle to one of NSLAVE slaves, returns data/ack,
// and turns decode faults and slave time-outs into bus errors.
module bus_router
    import bus_pkg::*;
#(
    parameter int NSLAVE  = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic [31:0]          adr_i,
    input  logic [3:0]           cs_i,
    input  logic                 fault_i,
    output logic                 ack_o,
    output logic                 err_o,
    output logic [DW-1:0]        dat_o,
    output logic [NSLAVE-1:0]    slv_stb_o,
    input  logic [NSLAVE-1:0]    slv_ack_i,
    input  logic [NSLAVE*DW-1:0] slv_dat_i,
    output logic                 fault_valid_o,
    output logic [1:0]           fault_cause_o,
    output logic [31:0]          fault_adr_o,
    output logic                 fault_ovr_o,
    input  logic                 fault_clr_i
);

    state_e        state_q, state_d;
    logic [3:0]    cs_q, cs_d;
    logic [31:0]   adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;

    logic          fv_q, fv_d;
    logic [1:0]    fc_q, fc_d;
    logic [31:0]   fa_q, fa_d;
    logic          fo_q, fo_d;

    logic          cap;
    logic [1:0]    cap_cause;
    logic [31:0]   cap_adr;
    logic          tmr_load;
    logic          tmr_en;
    logic          tmr_exp;

    bus_timeout #(.CW(CW)) u_tmo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (tmr_load),
        .en_i      (tmr_en),
        .val_i     (CW'(TIMEOUT)),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        cap       = 1'b0;
        cap_cause = 2'b00;
        cap_adr   = adr_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    if (fault_i || cs_i == 4'd0) begin
                        cap       = 1'b1;
                        cap_cause = CAUSE_DECODE;
                        cap_adr   = adr_i;
                        state_d   = ERR;
                    end else begin
                        cs_d     = cs_i;
                        adr_d    = adr_i;
                        tmr_load = 1'b1;
                        state_d  = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                tmr_en = 1'b1;
                // Ack is checked before expiry so a last-cycle ack still completes.
                if (!cyc_i) begin
                    state_d = IDLE;
                end else if (slv_ack_i[cs_q]) begin
                    dat_d   = slv_dat_i[cs_q*DW +: DW];
                    state_d = RESP;
                end else if (tmr_exp) begin
                    cap       = 1'b1;
                    cap_cause = CAUSE_TIMEOUT;
                    state_d   = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fv_d = fv_q;
        fc_d = fc_q;
        fa_d = fa_q;
        fo_d = fo_q;
        if (fault_clr_i) begin
            fv_d = cap;
            fo_d = 1'b0;
            if (cap) begin
                fc_d = cap_cause;
                fa_d = cap_adr;
            end
        end else if (cap) begin
            if (fv_q) begin
                fo_d = 1'b1;
            end else begin
                fv_d = 1'b1;
                fc_d = cap_cause;
                fa_d = cap_adr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cs_q    <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            fv_q    <= 1'b0;
            fc_q    <= 2'b00;
            fa_q    <= '0;
            fo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            fv_q    <= fv_d;
            fc_q    <= fc_d;
            fa_q    <= fa_d;
            fo_q    <= fo_d;
        end
    end

    always_comb begin
        slv_stb_o = '0;
        if (state_q == ACTIVE && cs_q != 4'd0) begin
            slv_stb_o[cs_q] = 1'b1;
        end
    end

    assign ack_o         = (state_q == RESP);
    assign err_o         = (state_q == ERR);
    assign dat_o         = dat_q;
    assign fault_valid_o = fv_q;
    assign fault_cause_o = fc_q;
    assign fault_adr_o   = fa_q;
    assign fault_ovr_o   = fo_q;

endmodule

// File: tb/tb_bus_router.sv
// Directed testbench for bus_router (TIMEOUT=4).
// Each task drives one scenario and checks hand-computed results.
module tb_bus_router;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          cyc_i;
    logic          stb_i;
    logic [31:0]   adr_i;
    logic [3:0]    cs_i;
    logic          fault_i;
    logic          ack_o;
    logic          err_o;
    logic [31:0]   dat_o;
    logic [15:0]   slv_stb_o;
    logic [15:0]   slv_ack_i;
    logic [511:0]  slv_dat_i;
    logic          fault_valid_o;
    logic [1:0]    fault_cause_o;
    logic [31:0]   fault_adr_o;
    logic          fault_ovr_o;
    logic          fault_clr_i;

    int passed = 0;
    int total  = 0;

    bus_router #(
        .NSLAVE  (16),
        .DW      (32),
        .TIMEOUT (4),
        .CW      (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .cyc_i         (cyc_i),
        .stb_i         (stb_i),
        .adr_i         (adr_i),
        .cs_i          (cs_i),
        .fault_i       (fault_i),
        .ack_o         (ack_o),
        .err_o         (err_o),
        .dat_o         (dat_o),
        .slv_stb_o     (slv_stb_o),
        .slv_ack_i     (slv_ack_i),
        .slv_dat_i     (slv_dat_i),
        .fault_valid_o (fault_valid_o),
        .fault_cause_o (fault_cause_o),
        .fault_adr_o   (fault_adr_o),
        .fault_ovr_o   (fault_ovr_o),
        .fault_clr_i   (fault_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [3:0] cs, input logic [31:0] adr,
                       input logic flt);
        cyc_i   = 1'b1;
        stb_i   = 1'b1;
        cs_i    = cs;
        adr_i   = adr;
        fault_i = flt;
    endtask

    task automatic idle_bus();
        cyc_i     = 1'b0;
        stb_i     = 1'b0;
        fault_i   = 1'b0;
        cs_i      = 4'd0;
        slv_ack_i = '0;
    endtask

    task automatic test_reset();
        rst_n_i     = 1'b0;
        fault_clr_i = 1'b0;
        adr_i       = '0;
        idle_bus();
        for (int k = 0; k < 16; k++) begin
            slv_dat_i[k*32 +: 32] = 32'hA000_0000 | k;
        end
        #3;
        total++;
        if ({ack_o, err_o, slv_stb_o, dat_o} !== 50'd0)
            $display("FAIL rst_out: ack=%0b err=%0b stb=%h dat=%h want 0",
                     ack_o, err_o, slv_stb_o, dat_o);
        else passed++;
        total++;
        if ({fault_valid_o, fault_cause_o, fault_adr_o, fault_ovr_o} !== 36'd0)
            $display("FAIL rst_fault: v=%0b c=%b a=%h o=%0b want 0",
                     fault_valid_o, fault_cause_o, fault_adr_o, fault_ovr_o);
        else passed++;
        tick();
        tick();
        #2;
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_normal_read();
        slv_dat_i[7*32 +: 32] = 32'hDEAD_BEEF;
        req(4'd7, 32'h7000_0010, 1'b0);
        tick();
        total++;
        if (slv_stb_o !== 16'h0080)
            $display("FAIL rd_stb: got %h want 0080", slv_stb_o);
        else passed++;
        tick();
        total++;
        if (ack_o !== 1'b0 || slv_stb_o !== 16'h0080)
            $display("FAIL rd_wait: ack=%0b stb=%h want 0/0080", ack_o, slv_stb_o);
        else passed++;
        tick();
        slv_ack_i[7] = 1'b1;
        tick();
        slv_ack_i = '0;
        cyc_i     = 1'b0;
        stb_i     = 1'b0;
        total++;
        if (ack_o !== 1'b1 || err_o !== 1'b0)
            $display("FAIL rd_ack: ack=%0b err=%0b want 1/0", ack_o, err_o);
        else passed++;
        total++;
        if (dat_o !== 32'hDEAD_BEEF)
            $display("FAIL rd_dat: got %h want deadbeef", dat_o);
        else passed++;
        total++;
        if (slv_stb_o !== 16'h0000)
            $display("FAIL rd_stb_off: got %h want 0000", slv_stb_o);
        else passed++;
        tick();
        total++;
        if (ack_o !== 1'b0)
            $display("FAIL rd_pulse: ack=%0b want 0", ack_o);
        else passed++;
    endtask

    task automatic test_decode_fault();
        req(4'd2, 32'h1000_0000, 1'b1);
        tick();
        idle_bus();
        total++;
        if (err_o !== 1'b1 || slv_stb_o !== 16'h0000)
            $display("FAIL dec_err: err=%0b stb=%h want 1/0000", err_o, slv_stb_o);
        else passed++;
        total++;
        if (fault_valid_o !== 1'b1 || fault_cause_o !== 2'b01 ||
            fault_adr_o !== 32'h1000_0000)
            $display("FAIL dec_rec: v=%0b c=%b a=%h want 1/01/10000000",
                     fault_valid_o, fault_cause_o, fault_adr_o);
        else passed++;
        tick();
        total++;
        if (err_o !== 1'b0)
            $display("FAIL dec_pulse: err=%0b want 0", err_o);
        else passed++;
        fault_clr_i = 1'b1;
        tick();
        fault_clr_i = 1'b0;
        total++;
        if (fault_valid_o !== 1'b0 || fault_ovr_o !== 1'b0)
            $display("FAIL dec_clr: v=%0b o=%0b want 0/0", fault_valid_o, fault_ovr_o);
        else passed++;
        req(4'd0, 32'h0000_0ABC, 1'b0);
        tick();
        idle_bus();
        total++;
        if (err_o !== 1'b1 || fault_adr_o !== 32'h0000_0ABC || slv_stb_o !== 16'h0)
            $display("FAIL cs0_err: err=%0b a=%h stb=%h want 1/00000abc/0000",
                     err_o, fault_adr_o, slv_stb_o);
        else passed++;
        fault_clr_i = 1'b1;
        tick();
        fault_clr_i = 1'b0;
    endtask

    task automatic test_timeout();
        logic [4:0] errs;
        req(4'd3, 32'h3000_0040, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            stb_i   = 1'b0;
            errs[c] = err_o;
            if (c == 0) begin
                total++;
                if (slv_stb_o !== 16'h0008)
                    $display("FAIL tmo_stb: got %h want 0008", slv_stb_o);
                else passed++;
            end
        end
        idle_bus();
        total++;
        if (errs !== 5'b10000)
            $display("FAIL tmo_timing: err per cycle %b want 10000", errs);
        else passed++;
        total++;
        if (fault_cause_o !== 2'b10 || fault_adr_o !== 32'h3000_0040 ||
            fault_valid_o !== 1'b1 || fault_ovr_o !== 1'b0)
            $display("FAIL tmo_rec: v=%0b c=%b a=%h o=%0b want 1/10/30000040/0",
                     fault_valid_o, fault_cause_o, fault_adr_o, fault_ovr_o);
        else passed++;
        tick();
        req(4'd1, 32'h2222_0000, 1'b1);
        tick();
        idle_bus();
        total++;
        if (err_o !== 1'b1 || fault_ovr_o !== 1'b1 ||
            fault_adr_o !== 32'h3000_0040 || fault_cause_o !== 2'b10)
            $display("FAIL tmo_ovr: err=%0b o=%0b a=%h c=%b want 1/1/30000040/10",
                     err_o, fault_ovr_o, fault_adr_o, fault_cause_o);
        else passed++;
        tick();
        req(4'd1, 32'h5555_0000, 1'b1);
        fault_clr_i = 1'b1;
        tick();
        idle_bus();
        fault_clr_i = 1'b0;
        total++;
        if (fault_valid_o !== 1'b1 || fault_ovr_o !== 1'b0 ||
            fault_adr_o !== 32'h5555_0000 || fault_cause_o !== 2'b01)
            $display("FAIL clr_cap: v=%0b o=%0b a=%h c=%b want 1/0/55550000/01",
                     fault_valid_o, fault_ovr_o, fault_adr_o, fault_cause_o);
        else passed++;
        tick();
    endtask

    task automatic test_edge_cases();
        slv_dat_i[5*32 +: 32] = 32'h5A5A_0005;
        req(4'd5, 32'h5000_0000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            stb_i = 1'b0;
        end
        slv_ack_i[5] = 1'b1;
        tick();
        idle_bus();
        total++;
        if (ack_o !== 1'b1 || err_o !== 1'b0 || dat_o !== 32'h5A5A_0005)
            $display("FAIL exp_ack: ack=%0b err=%0b dat=%h want 1/0/5a5a0005",
                     ack_o, err_o, dat_o);
        else passed++;
        tick();
        total++;
        if (ack_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL exp_after: ack=%0b err=%0b want 0/0", ack_o, err_o);
        else passed++;

        req(4'd6, 32'h6000_0000, 1'b0);
        tick();
        idle_bus();
        tick();
        total++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || slv_stb_o !== 16'h0)
            $display("FAIL abort: ack=%0b err=%0b stb=%h want 0/0/0000",
                     ack_o, err_o, slv_stb_o);
        else passed++;
        tick();
        total++;
        if (ack_o !== 1'b0 || err_o !== 1'b0 || fault_adr_o !== 32'h5555_0000)
            $display("FAIL abort_late: ack=%0b err=%0b a=%h want 0/0/55550000",
                     ack_o, err_o, fault_adr_o);
        else passed++;

        slv_ack_i = 16'hFFFF;
        tick();
        tick();
        total++;
        if (ack_o !== 1'b0 || slv_stb_o !== 16'h0)
            $display("FAIL idle_ack: ack=%0b stb=%h want 0/0000", ack_o, slv_stb_o);
        else passed++;
        slv_ack_i = '0;

        req(4'd9, 32'h9000_0000, 1'b0);
        slv_ack_i[2] = 1'b1;
        tick();
        stb_i = 1'b0;
        tick();
        total++;
        if (ack_o !== 1'b0 || slv_stb_o !== 16'h0200)
            $display("FAIL other_ack: ack=%0b stb=%h want 0/0200", ack_o, slv_stb_o);
        else passed++;
        slv_ack_i[9] = 1'b1;
        tick();
        idle_bus();
        total++;
        if (ack_o !== 1'b1 || dat_o !== 32'hA000_0009)
            $display("FAIL sel_ack: ack=%0b dat=%h want 1/a0000009", ack_o, dat_o);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_active();
        req(4'd7, 32'h7777_0000, 1'b0);
        tick();
        stb_i = 1'b0;
        total++;
        if (slv_stb_o !== 16'h0080)
            $display("FAIL mid_pre: stb=%h want 0080", slv_stb_o);
        else passed++;
        #2;
        rst_n_i = 1'b0;
        #1;
        total++;
        if ({ack_o, err_o, slv_stb_o, dat_o} !== 50'd0)
            $display("FAIL mid_rst: ack=%0b err=%0b stb=%h dat=%h want 0",
                     ack_o, err_o, slv_stb_o, dat_o);
        else passed++;
        total++;
        if ({fault_valid_o, fault_cause_o, fault_adr_o, fault_ovr_o} !== 36'd0)
            $display("FAIL mid_fault: v=%0b c=%b a=%h o=%0b want 0",
                     fault_valid_o, fault_cause_o, fault_adr_o, fault_ovr_o);
        else passed++;
        idle_bus();
        tick();
        rst_n_i = 1'b1;
        tick();
        req(4'd4, 32'h4000_0000, 1'b0);
        tick();
        idle_bus();
        total++;
        if (slv_stb_o !== 16'h0010)
            $display("FAIL post_rst: stb=%h want 0010", slv_stb_o);
        else passed++;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_normal_read();
        test_decode_fault();
        test_timeout();
        test_edge_cases();
        test_reset_mid_active();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
